// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack bus transaction with pipeline stall and load alignment/extension.
// Optional REQ-state timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        align_err,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [29:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, nextState;
  logic        isOp, misaligned, startOp, timeout;
  logic        isLoadL, unsL;
  logic [1:0]  offL, sizeL;
  logic [3:0]  beNext;
  logic [31:0] wdNext, loadVal;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign isOp       = mem_read | mem_write;
  assign misaligned = (size[1] && addr[1:0] != 2'b00) || (size == 2'b01 && addr[0]);
  assign startOp    = (state == IDLE) && isOp && !misaligned;
  assign stall      = !reset && (startOp || state == REQ);
  assign align_err  = !reset && (state == IDLE) && isOp && misaligned;

`ifdef MEM_TIMEOUT_EN
  logic [15:0] reqCnt;

  assign timeout = (state == REQ) && !dm_ack && (reqCnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || startOp)
      reqCnt <= '0;
    else if (state == REQ && !dm_ack)
      reqCnt <= reqCnt + 16'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    beNext = 4'b1111;
    wdNext = wdata;
    case (size)
      2'b00: begin
        beNext = 4'b0001 << addr[1:0];
        wdNext = {4{wdata[7:0]}};
      end
      2'b01: begin
        beNext = addr[1] ? 4'b1100 : 4'b0011;
        wdNext = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset latched at request time, not the live addr.
  always_comb begin
    loadByte = dm_rdata[{offL, 3'b000} +: 8];
    loadHalf = offL[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (sizeL)
      2'b00:   loadVal = {{24{!unsL & loadByte[7]}}, loadByte};
      2'b01:   loadVal = {{16{!unsL & loadHalf[15]}}, loadHalf};
      default: loadVal = dm_rdata;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startOp) nextState = REQ;
      REQ:     if (dm_ack || timeout) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      read_data <= '0;
      bus_err   <= 1'b0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_be     <= '0;
      dm_wdata  <= '0;
      isLoadL   <= 1'b0;
      unsL      <= 1'b0;
      offL      <= '0;
      sizeL     <= '0;
    end else begin
      state   <= nextState;
      bus_err <= timeout;
      if (startOp) begin
        dm_req   <= 1'b1;
        dm_we    <= mem_write;
        dm_addr  <= addr[31:2];
        dm_be    <= beNext;
        dm_wdata <= wdNext;
        isLoadL  <= mem_read;
        unsL     <= unsigned_ld;
        offL     <= addr[1:0];
        sizeL    <= size;
      end
      if (state == REQ && (dm_ack || timeout)) begin
        dm_req <= 1'b0;
        if (dm_ack) begin
          if (isLoadL) read_data <= loadVal;
        end else begin
          read_data <= '0;
        end
      end
    end
  end

endmodule
